// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - two-port round-robin sequencer for the shared 5-bit ALU
module alu_req_arbiter #(
    parameter int W      = 5,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [1:0]   req0_op,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req1_op,
    input  logic         req1_cin,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_r,
    output logic         rsp0_c,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_r,
    output logic         rsp1_c,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    output logic         alu_cin,
    input  logic [W-1:0] alu_r,
    input  logic         alu_c,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] SETTLE_L = 3'(SETTLE);

    state_t         state;
    state_t         state_nx;
    logic           ptr;
    logic           owner;
    logic [2:0]     cnt;
    logic [W-1:0]   res_r;
    logic           res_c;
    logic           gnt0;
    logic           gnt1;
    logic           accept;
    logic           rsp_take;

    // ptr names the requester served last; on a tie the other one wins
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | ptr);
        gnt1 = req1_valid & (~req0_valid | ~ptr);
    end

    assign req0_ready = (state == IDLE) & gnt0;
    assign req1_ready = (state == IDLE) & gnt1;
    assign accept     = req0_ready | req1_ready;
    assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = WAIT;
            WAIT:    if (cnt == 3'd1) state_nx = RESP;
            RESP:    if (rsp_take) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 1'b1;
            owner   <= 1'b0;
            cnt     <= 3'd0;
            res_r   <= '0;
            res_c   <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= 2'd0;
            alu_cin <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                alu_a   <= gnt1 ? req1_a   : req0_a;
                alu_b   <= gnt1 ? req1_b   : req0_b;
                alu_op  <= gnt1 ? req1_op  : req0_op;
                alu_cin <= gnt1 ? req1_cin : req0_cin;
                owner   <= gnt1;
                ptr     <= gnt1;
                cnt     <= SETTLE_L;
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
                // ALU inputs have been stable for SETTLE cycles by this edge
                if (cnt == 3'd1) begin
                    res_r <= alu_r;
                    res_c <= alu_c;
                end
            end
        end
    end

    assign busy       = (state != IDLE);
    assign rsp0_valid = (state == RESP) & ~owner;
    assign rsp1_valid = (state == RESP) & owner;
    assign rsp0_r     = res_r;
    assign rsp1_r     = res_r;
    assign rsp0_c     = res_c;
    assign rsp1_c     = res_c;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;

    localparam int S1 = 1;

    logic clk, rst_n;
    logic req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
    logic [4:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op, alu_op;
    logic rsp0_valid, rsp0_ready, rsp0_c, rsp1_valid, rsp1_ready, rsp1_c;
    logic [4:0] rsp0_r, rsp1_r, alu_a, alu_b, alu_r;
    logic alu_cin, alu_c, busy;

    logic q_req0_valid, q_req0_ready, q_req1_ready;
    logic [1:0] q_alu_op;
    logic q_rsp0_valid, q_rsp0_c, q_rsp1_valid, q_rsp1_c, q_alu_cin, q_alu_c, q_busy;
    logic [4:0] q_rsp0_r, q_rsp1_r, q_alu_a, q_alu_b, q_alu_r;

    int n_cmp = 0;
    int n_bad = 0;

    alu_req_arbiter #(.W(5), .SETTLE(S1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_cin(req1_cin),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_r(rsp0_r), .rsp0_c(rsp0_c),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r), .rsp1_c(rsp1_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_r(alu_r), .alu_c(alu_c), .busy(busy)
    );

    alu_req_arbiter #(.W(5), .SETTLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(q_req0_valid), .req0_ready(q_req0_ready), .req0_a(5'd3), .req0_b(5'd3),
        .req0_op(2'd1), .req0_cin(1'b0),
        .req1_valid(1'b0), .req1_ready(q_req1_ready), .req1_a(5'd0), .req1_b(5'd0),
        .req1_op(2'd0), .req1_cin(1'b0),
        .rsp0_valid(q_rsp0_valid), .rsp0_ready(1'b1), .rsp0_r(q_rsp0_r), .rsp0_c(q_rsp0_c),
        .rsp1_valid(q_rsp1_valid), .rsp1_ready(1'b1), .rsp1_r(q_rsp1_r), .rsp1_c(q_rsp1_c),
        .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_op(q_alu_op), .alu_cin(q_alu_cin),
        .alu_r(q_alu_r), .alu_c(q_alu_c), .busy(q_busy)
    );

    // ALU behaviour: {C, R}
    function automatic logic [5:0] alu_f(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                                         input logic cin);
        logic [9:0] p;
        logic signed [9:0] sp;
        int d;
        case (op)
            2'd0: alu_f = {a < b, 5'd0};
            2'd1: begin
                sp = $signed(a) * $signed(b);
                alu_f = {sp[9], sp[6:2]};
            end
            2'd2: begin
                p = a * b;
                alu_f = {|p[9:7], p[6:2]};
            end
            default: begin
                d = int'(a) - int'(b) + int'(cin);
                alu_f = {d < 0, d[4:0]};
            end
        endcase
    endfunction

    assign {alu_c, alu_r} = alu_f(alu_op, alu_a, alu_b, alu_cin);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one job in flight, age = edges since acceptance
    logic m_busy, m_owner, m_ptr, m_cin, m_rc;
    logic [4:0] m_a, m_b, m_rr;
    logic [1:0] m_op;
    int m_age, m_g;

    function automatic int grant_f(input logic bz, input logic last, input logic v0, input logic v1);
        if (bz) return -1;
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    assign m_g = grant_f(m_busy, m_ptr, req0_valid, req1_valid);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_owner <= 0; m_ptr <= 1; m_age <= 0;
            m_a <= 0; m_b <= 0; m_op <= 0; m_cin <= 0; m_rr <= 0; m_rc <= 0;
        end else if (m_busy) begin
            if (m_age < S1) begin
                m_age <= m_age + 1;
                if (m_age + 1 == S1) {m_rc, m_rr} <= alu_f(m_op, m_a, m_b, m_cin);
            end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_busy <= 0;
            end
        end else if (m_g >= 0) begin
            m_busy <= 1; m_age <= 0;
            m_owner <= (m_g == 1); m_ptr <= (m_g == 1);
            m_a   <= (m_g == 1) ? req1_a   : req0_a;
            m_b   <= (m_g == 1) ? req1_b   : req0_b;
            m_op  <= (m_g == 1) ? req1_op  : req0_op;
            m_cin <= (m_g == 1) ? req1_cin : req0_cin;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("req0_ready", req0_ready, m_g == 0);
        chk("req1_ready", req1_ready, m_g == 1);
        chk("rsp0_valid", rsp0_valid, m_busy && m_age >= S1 && !m_owner);
        chk("rsp1_valid", rsp1_valid, m_busy && m_age >= S1 && m_owner);
        chk("rsp0_r", rsp0_r, m_rr);
        chk("rsp1_r", rsp1_r, m_rr);
        chk("rsp0_c", rsp0_c, m_rc);
        chk("rsp1_c", rsp1_c, m_rc);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
        chk("alu_cin", alu_cin, m_cin);
    end

    function automatic logic rdy(input int p);
        return (p == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic vld(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [1:0] op, input logic [4:0] a,
                           input logic [4:0] b, input logic cin);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
        end
    endtask

    task automatic wait_ready(input int p);
        int n = 0;
        while (!rdy(p) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int p, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!vld(p) && n < 20);
        if (!vld(p)) chk("rsp_timeout", 0, 1);
    endtask

    // Issue one request from an idle controller and check the returned result
    task automatic single(input string tag, input int p, input logic [1:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic cin, input logic [4:0] er, input logic ec);
        int n;
        set_req(p, 1, op, a, b, cin); #1;
        chk({tag, "_ready"}, rdy(p), 1);
        @(posedge clk); #1;
        set_req(p, 0, op, a, b, cin);
        wait_rsp(p, n);
        chk({tag, "_lat"}, n, S1);
        chk({tag, "_r"}, (p == 1) ? rsp1_r : rsp0_r, er);
        chk({tag, "_c"}, (p == 1) ? rsp1_c : rsp0_c, ec);
        @(posedge clk); #1;
    endtask

    task automatic tie_round(input logic [1:0] op0, input logic [4:0] a0, input logic [4:0] b0,
                             input logic cin0, input logic [4:0] r0, input logic c0,
                             input logic [1:0] op1, input logic [4:0] a1, input logic [4:0] b1,
                             input logic cin1, input logic [4:0] r1, input logic c1);
        int n;
        set_req(0, 1, op0, a0, b0, cin0);
        set_req(1, 1, op1, a1, b1, cin1); #1;
        chk("tie_ready0", req0_ready, 1);
        chk("tie_ready1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0;
        wait_rsp(0, n);
        chk("tie_r0", rsp0_r, r0);
        chk("tie_c0", rsp0_c, c0);
        wait_ready(1);
        @(posedge clk); #1;
        req1_valid = 0;
        wait_rsp(1, n);
        chk("tie_r1", rsp1_r, r1);
        chk("tie_c1", rsp1_c, c1);
        @(posedge clk); #1;
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 0;
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        rsp0_ready = 1; rsp1_ready = 1;
        q_req0_valid = 0; q_alu_r = 0; q_alu_c = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        rst_n = 1;

        single("sub", 0, 2'd3, 5'd7, 5'd2, 1'b1, 5'd6, 1'b0);
        single("cmp_lt", 1, 2'd0, 5'd3, 5'd5, 1'b0, 5'd0, 1'b1);
        single("cmp_gt", 1, 2'd0, 5'd6, 5'd5, 1'b0, 5'd0, 1'b0);

        #1 rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        tie_round(2'd2, 5'b11100, 5'd3, 1'b0, 5'd21, 1'b0,
                  2'd3, 5'd4, 5'd4, 1'b0, 5'd0, 1'b0);
        tie_round(2'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1,
                  2'd3, 5'd9, 5'd4, 1'b0, 5'd5, 1'b0);

        // response backpressure
        rsp0_ready = 0;
        set_req(0, 1, 2'd3, 5'd10, 5'd3, 1'b0);
        @(posedge clk); #1;
        req0_valid = 0;
        set_req(1, 1, 2'd0, 5'd2, 5'd2, 1'b0);
        wait_rsp(0, n);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp0_valid, 1);
            chk("bp_r", rsp0_r, 5'd7);
            chk("bp_c", rsp0_c, 0);
            chk("bp_req1_ready", req1_ready, 0);
            @(posedge clk); #1;
        end
        rsp0_ready = 1;
        @(posedge clk); #1;
        chk("bp_after_ready1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        chk("bp_req1_busy", busy, 1);
        wait_rsp(1, n);
        chk("bp_r1", rsp1_r, 5'd0);
        chk("bp_c1", rsp1_c, 1'b0);
        @(posedge clk); #1;

        // reset in the middle of WAIT
        set_req(0, 1, 2'd3, 5'd7, 5'd2, 1'b1);
        @(posedge clk); #1;
        req0_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_alu_a", alu_a, 0);
        chk("mrst_alu_b", alu_b, 0);
        chk("mrst_alu_op", alu_op, 0);
        chk("mrst_alu_cin", alu_cin, 0);
        chk("mrst_rsp0_valid", rsp0_valid, 0);
        chk("mrst_rsp1_valid", rsp1_valid, 0);
        chk("mrst_rsp_r", rsp0_r, 0);
        chk("mrst_rsp_c", rsp0_c, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        set_req(1, 1, 2'd3, 5'd5, 5'd1, 1'b0); #1;
        chk("mrst_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        wait_rsp(1, n);
        chk("mrst_r1", rsp1_r, 5'd4);
        chk("mrst_no_rsp0", rsp0_valid, 0);
        @(posedge clk); #1;

        // SETTLE=4 instance: only the ALU value just before edge k+4 is captured
        q_req0_valid = 1; #1;
        chk("s4_ready", q_req0_ready, 1);
        @(posedge clk); #1;
        q_req0_valid = 0;
        chk("s4_alu_a", q_alu_a, 5'd3);
        chk("s4_alu_op", q_alu_op, 2'd1);
        chk("s4_busy", q_busy, 1);
        q_alu_r = 5'd1;
        @(posedge clk); #1;
        chk("s4_v_k1", q_rsp0_valid, 0);
        q_alu_r = 5'd2;
        @(posedge clk); #1;
        chk("s4_v_k2", q_rsp0_valid, 0);
        q_alu_r = 5'd22; q_alu_c = 1;
        @(posedge clk); #1;
        chk("s4_v_k3", q_rsp0_valid, 0);
        @(posedge clk); #1;
        q_alu_r = 5'd17; q_alu_c = 0;
        chk("s4_valid", q_rsp0_valid, 1);
        chk("s4_r", q_rsp0_r, 5'd22);
        chk("s4_c", q_rsp0_c, 1);
        chk("s4_rsp1", q_rsp1_valid, 0);
        @(posedge clk); #1;
        chk("s4_idle", q_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
